// File: rtl/dtw_pkg.sv
// Shared DTW definitions: state codes and state width, also used by the
// sample-memory write-enable decoder.
package dtw_pkg;

    localparam int DTW_STATE_W = 4;

    typedef enum logic [DTW_STATE_W-1:0] {
        DTW_INITIAL          = 4'd0,
        DTW_TEMP_FILL        = 4'd1,
        DTW_TEST_FILL        = 4'd2,
        DTW_FIRST_CELL       = 4'd3,
        DTW_FIRST_ROW        = 4'd4,
        DTW_ODD_FIRST_CELL   = 4'd5,
        DTW_ODD_ROW          = 4'd6,
        DTW_EVEN_FIRST_CELL  = 4'd7,
        DTW_EVEN_ROW         = 4'd8,
        DTW_FINAL            = 4'd9
    } dtw_state_e;

    // Row-sweep state that follows the first cell of a row.
    function automatic dtw_state_e dtw_row_state(input logic first_row, input logic odd_row);
        if (first_row)
            return DTW_FIRST_ROW;
        else if (odd_row)
            return DTW_ODD_ROW;
        else
            return DTW_EVEN_ROW;
    endfunction

endpackage

// File: rtl/dtw_index_counter.sv
// Index counter with synchronous clear, count enable and terminal-count
// compare against a supplied last value.
module dtw_index_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] q,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q + 1'b1;
    end

    assign tc = (q == last);

endmodule

// File: rtl/dtw_sequencer.sv
// DTW pass sequencer: fills template/test memories, then walks the cost
// matrix one cell per cycle. Optional abort input under DTW_SEQ_ABORT_EN.
module dtw_sequencer
    import dtw_pkg::*;
#(
    parameter int N_LEN = 16,
    parameter int M_LEN = 16,
    parameter int IDX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic [DTW_STATE_W-1:0] dtw_state,
    output logic [IDX_W-1:0]       fill_addr,
    output logic [IDX_W-1:0]       col,
    output logic [IDX_W-1:0]       row,
    output logic                   done
`ifdef DTW_SEQ_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    // Handshake: in_valid has no ready; in a fill state every in_valid cycle
    // writes one sample at fill_addr and the sequencer always accepts it.
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_LEN - 1);
    localparam logic [IDX_W-1:0] M_LAST = IDX_W'(M_LEN - 1);

    dtw_state_e       state_q, state_d;
    logic             fill_clr, fill_en, fill_tc;
    logic             col_clr, col_en, col_tc;
    logic             row_clr, row_en, row_tc;
    logic             abort_i;
    logic [IDX_W-1:0] fill_last;

`ifdef DTW_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign fill_last = (state_q == DTW_TEST_FILL) ? M_LAST : N_LAST;

    always_comb begin
        state_d  = state_q;
        fill_clr = 1'b0;
        fill_en  = 1'b0;
        col_clr  = 1'b0;
        col_en   = 1'b0;
        row_clr  = 1'b0;
        row_en   = 1'b0;
        case (state_q)
            DTW_INITIAL: begin
                if (start) begin
                    state_d  = DTW_TEMP_FILL;
                    fill_clr = 1'b1;
                    col_clr  = 1'b1;
                    row_clr  = 1'b1;
                end
            end
            DTW_TEMP_FILL, DTW_TEST_FILL: begin
                if (in_valid) begin
                    if (fill_tc) begin
                        state_d  = (state_q == DTW_TEMP_FILL) ? DTW_TEST_FILL : DTW_FIRST_CELL;
                        fill_clr = 1'b1;
                    end else begin
                        fill_en = 1'b1;
                    end
                end
            end
            DTW_FIRST_CELL, DTW_FIRST_ROW, DTW_ODD_FIRST_CELL,
            DTW_ODD_ROW, DTW_EVEN_FIRST_CELL, DTW_EVEN_ROW: begin
                if (col_tc) begin
                    col_clr = 1'b1;
                    if (row_tc) begin
                        state_d = DTW_FINAL;
                    end else begin
                        row_en  = 1'b1;
                        // Next row is odd exactly when the current one is even.
                        state_d = row[0] ? DTW_EVEN_FIRST_CELL : DTW_ODD_FIRST_CELL;
                    end
                end else begin
                    col_en  = 1'b1;
                    state_d = dtw_row_state(row == '0, row[0]);
                end
            end
            DTW_FINAL: begin
                if (!start)
                    state_d = DTW_INITIAL;
            end
            default: state_d = DTW_INITIAL;
        endcase
        if (abort_i) begin
            state_d  = DTW_INITIAL;
            fill_clr = 1'b1;
            col_clr  = 1'b1;
            row_clr  = 1'b1;
            fill_en  = 1'b0;
            col_en   = 1'b0;
            row_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DTW_INITIAL;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == DTW_FINAL);
        end
    end

    assign dtw_state = state_q;

    dtw_index_counter #(.W(IDX_W)) u_fill_cnt (
        .clk(clk), .rst_n(rst_n), .clr(fill_clr), .en(fill_en),
        .last(fill_last), .q(fill_addr), .tc(fill_tc)
    );

    dtw_index_counter #(.W(IDX_W)) u_col_cnt (
        .clk(clk), .rst_n(rst_n), .clr(col_clr), .en(col_en),
        .last(N_LAST), .q(col), .tc(col_tc)
    );

    dtw_index_counter #(.W(IDX_W)) u_row_cnt (
        .clk(clk), .rst_n(rst_n), .clr(row_clr), .en(row_en),
        .last(M_LAST), .q(row), .tc(row_tc)
    );

endmodule

// File: tb/tb_dtw_sequencer.sv
// Bench for dtw_sequencer: a 4x4 instance and a 1x3 instance driven with
// randomized fill gaps and checked against a cell-walk reference model.
module tb_dtw_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v[2];
    logic       in_valid_v[2];
    logic       abort_v[2];
    logic [3:0] st_o[2];
    logic [7:0] fa_o[2];
    logic [7:0] col_o[2];
    logic [7:0] row_o[2];
    logic       done_o[2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // {state, row, col} per expected compute cycle
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    dtw_sequencer #(.N_LEN(4), .M_LEN(4), .IDX_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid_v[0]),
        .dtw_state(st_o[0]), .fill_addr(fa_o[0]), .col(col_o[0]), .row(row_o[0]),
        .done(done_o[0])
`ifdef DTW_SEQ_ABORT_EN
        , .abort(abort_v[0])
`endif
    );

    dtw_sequencer #(.N_LEN(1), .M_LEN(3), .IDX_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid_v[1]),
        .dtw_state(st_o[1]), .fill_addr(fa_o[1]), .col(col_o[1]), .row(row_o[1]),
        .done(done_o[1])
`ifdef DTW_SEQ_ABORT_EN
        , .abort(abort_v[1])
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference walk: rows top to bottom, columns left to right.
    task automatic build_walk(input int n, input int m);
        int st;
        exp_q.delete();
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                if (i == 0)          st = (j == 0) ? 3 : 4;
                else if (i % 2 == 1) st = (j == 0) ? 5 : 6;
                else                 st = (j == 0) ? 7 : 8;
                exp_q.push_back({4'(st), 8'(i), 8'(j)});
            end
        end
    endtask

    task automatic do_fill(input int d, input int len, input int cur_st, input int nxt_st);
        int cnt = 0;
        int gaps = 0;
        logic v;
        while (cnt < len) begin
            v = ($urandom_range(0, 2) != 0) || (gaps >= 2);
            gaps = v ? 0 : gaps + 1;
            in_valid_v[d] = v;
            step();
            if (v) cnt++;
            if (v && cnt == len) begin
                chk("fill_exit_state", 32'(st_o[d]), 32'(nxt_st));
                if (nxt_st == 2) chk("fill_addr_cleared", 32'(fa_o[d]), 0);
            end else begin
                chk("fill_state", 32'(st_o[d]), 32'(cur_st));
                chk("fill_addr", 32'(fa_o[d]), 32'(cnt));
            end
        end
        in_valid_v[d] = 1'b0;
    endtask

    // Checks the first 'upto' cells; a full walk also checks entry to final.
    task automatic run_compute(input int d, input int n, input int m, input int upto);
        logic [19:0] e;
        build_walk(n, m);
        for (int k = 0; k < upto; k++) begin
            if (k > 0) step();
            e = exp_q.pop_front();
            chk("cell_state", 32'(st_o[d]), 32'(e[19:16]));
            chk("cell_row", 32'(row_o[d]), 32'(e[15:8]));
            chk("cell_col", 32'(col_o[d]), 32'(e[7:0]));
            chk("cell_done", 32'(done_o[d]), 0);
        end
        if (upto == n * m) begin
            step();
            chk("final_state", 32'(st_o[d]), 9);
            chk("final_done", 32'(done_o[d]), 1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            in_valid_v[d] = 1'b0;
            abort_v[d] = 1'b0;
        end
        #2;
        chk("rst_state", 32'(st_o[0]), 0);
        chk("rst_fill", 32'(fa_o[0]), 0);
        chk("rst_col", 32'(col_o[0]), 0);
        chk("rst_row", 32'(row_o[0]), 0);
        chk("rst_done", 32'(done_o[0]), 0);
        #10 rst_n = 1'b1;
        step();
        chk("idle_state", 32'(st_o[0]), 0);

        // 4x4 full pass with random valid gaps
        start_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        step();
        chk("start_state", 32'(st_o[0]), 1);
        chk("start_fill", 32'(fa_o[0]), 0);
        do_fill(0, 4, 1, 2);
        do_fill(0, 4, 2, 3);
        run_compute(0, 4, 4, 16);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_state", 32'(st_o[0]), 9);
            chk("hold_done", 32'(done_o[0]), 1);
        end
        start_v[0] = 1'b0;
        step();
        chk("drop_state", 32'(st_o[0]), 0);
        chk("drop_done", 32'(done_o[0]), 0);
        step();
        chk("stay_idle", 32'(st_o[0]), 0);

        // 1x3 pass: first-cell states only
        start_v[1] = 1'b1;
        step();
        chk("b_start_state", 32'(st_o[1]), 1);
        do_fill(1, 1, 1, 2);
        do_fill(1, 3, 2, 3);
        run_compute(1, 1, 3, 3);
        start_v[1] = 1'b0;
        step();
        chk("b_drop_state", 32'(st_o[1]), 0);

        // 4x4 pass interrupted by reset at state 6, row 1, col 2
        start_v[0] = 1'b1;
        step();
        do_fill(0, 4, 1, 2);
        do_fill(0, 4, 2, 3);
        run_compute(0, 4, 4, 7);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(st_o[0]), 0);
        chk("arst_fill", 32'(fa_o[0]), 0);
        chk("arst_col", 32'(col_o[0]), 0);
        chk("arst_row", 32'(row_o[0]), 0);
        chk("arst_done", 32'(done_o[0]), 0);
        start_v[0] = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(st_o[0]), 0);
        start_v[0] = 1'b1;
        step();
        chk("post_rst_start", 32'(st_o[0]), 1);

`ifdef DTW_SEQ_ABORT_EN
        do_fill(0, 4, 1, 2);
        do_fill(0, 4, 2, 3);
        run_compute(0, 4, 4, 2);
        abort_v[0] = 1'b1;
        start_v[0] = 1'b0;
        step();
        abort_v[0] = 1'b0;
        chk("abort_state", 32'(st_o[0]), 0);
        chk("abort_col", 32'(col_o[0]), 0);
        chk("abort_row", 32'(row_o[0]), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dtw_sequencer.md
DTW_SEQUENCER -- requirements
Module: dtw_sequencer

Interface
REQ-001 SHALL have parameter N_LEN, default 16, meaning template sequence length (>=1).
REQ-002 SHALL have parameter M_LEN, default 16, meaning test sequence length (>=1).
REQ-003 SHALL have parameter IDX_W, default 8, meaning width of index outputs (2^IDX_W >= max(N_LEN,M_LEN)).
REQ-004 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  level request to run one DTW pass.
REQ-007 SHALL have port in_valid  input  1  one sample written this cycle during fill states.
REQ-008 SHALL have port dtw_state  output  4  current state code, consumed by the memory write-enable decoder.
REQ-009 SHALL have port fill_addr  output  IDX_W  write address for the template/test sample memories.
REQ-010 SHALL have port col  output  IDX_W  template index j of the cell being computed.
REQ-011 SHALL have port row  output  IDX_W  test index i of the cell being computed.
REQ-012 SHALL have port done  output  1  high while in final_state.

Function
REQ-013 SHALL encode states: initial 0, temp_fill 1, test_fill 2, calculate_first_cell 3, calculate_first_row 4, calculate_odd_first_cell 5, calculate_odd_row 6, calculate_even_first_cell 7, calculate_even_row 8, final 9; codes 10-15 go to initial on the next clock.
REQ-014 SHALL move initial->temp_fill when start=1, clearing fill_addr, col and row.
REQ-015 SHALL, in both fill states, increment fill_addr by 1 per in_valid cycle and hold it otherwise.
REQ-016 SHALL leave temp_fill for test_fill on in_valid with fill_addr==N_LEN-1, with fill_addr cleared to 0.
REQ-017 SHALL leave test_fill for calculate_first_cell on in_valid with fill_addr==M_LEN-1.
REQ-018 SHALL stay exactly one cycle in any first_cell state (3, 5, 7), with col=0.
REQ-019 SHALL increment col by 1 per cycle in row states (4, 6, 8), starting at 1.
REQ-020 SHALL skip the row state when N_LEN==1; the first_cell state then acts as the last column.
REQ-021 SHALL, at the last column (col==N_LEN-1), go to final if row==M_LEN-1; otherwise increment row and go to odd_first_cell if the new row is odd, else even_first_cell.
REQ-022 SHALL hold final_state with done=1 while start=1 and return to initial on the cycle after start=0.
REQ-023 SHALL ignore start outside initial and final; SHALL ignore in_valid outside fill states.
REQ-024 SHALL register all outputs with no combinational path from any input to any output.
REQ-025 SHALL compute one cell per cycle, so the compute phase lasts exactly N_LEN*M_LEN cycles.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-pass, asynchronously force dtw_state=0, fill_addr=0, col=0, row=0 and done=0.
REQ-027 SHALL resume from initial on the first clock after rst_n rises and require a new start.

Configuration
REQ-028 SHALL, with macro DTW_SEQ_ABORT_EN defined, add input abort (1 bit): abort=1 in any state forces initial and clears counters on the next clock, with abort taking priority over all transitions.
REQ-029 SHALL, without DTW_SEQ_ABORT_EN, have no abort port and behaviour exactly as REQ-013..027.

Structure
REQ-030 SHALL take the ten state codes and the 4-bit state width from shared package dtw_pkg, which the memory write-enable decoder also uses.
REQ-031 SHALL instantiate the sub-module dtw_index_counter (clear, enable, terminal-count compare) for fill_addr, col and row.

Verification
REQ-032 SHALL cover: N=M=4, start=1, 4+4 in_valid pulses -> state sequence 1,2,3,4x3,5,6x3,7,8x3,5,6x3,9, with 16 compute cycles.
REQ-033 SHALL cover: in_valid gaps during temp_fill -> fill_addr holds, transition only on the 4th valid.
REQ-034 SHALL cover: N=1, M=3 -> 3,5,7,9 with row 0,1,2 and col always 0.
REQ-035 SHALL cover: rst_n low during state 6 at row 1, col 2 -> all outputs 0 immediately, with no clock needed.
REQ-036 SHALL cover: done=1 in state 9, start dropped -> state 0 next cycle, done=0.
REQ-037 SHALL cover, with DTW_SEQ_ABORT_EN: abort pulsed in state 4 -> state 0 next cycle, col=0.
